// File: rtl/seven_bit_cmp_ctrl.sv
// Pushbutton front-end and compare sequencer for the 7-bit magnitude comparator.
// Optional macro SEVEN_BIT_DEBOUNCE_EN inserts a per-button debounce counter after the synchroniser.
`timescale 1ns/1ps

module seven_bit_cmp_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] y,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic       pb4,
    input  logic       cmp_gt,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    output logic [6:0] a_out,
    output logic [6:0] b_out,
    output logic       cmp_start,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        LATCH,
        SHOW
    } state_e;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("seven_bit_cmp_ctrl: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [3:0] pb_pin;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] lvl;
    logic [3:0] lvl_prev_q;
    logic [3:0] ev_q;
    logic       ev_any;

    assign pb_pin = {pb4, pb3, pb2, pb1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pb_pin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef SEVEN_BIT_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       deb_q;
    logic [CNT_W-1:0] cnt_q [4];

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreement reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (sync_q[SYNC_STAGES-1][n] == deb_q[n]) begin
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] == CNT_LAST) begin
                    deb_q[n] <= sync_q[SYNC_STAGES-1][n];
                    cnt_q[n] <= '0;
                end else begin
                    cnt_q[n] <= cnt_q[n] + 1'b1;
                end
            end
        end
    end

    assign lvl = deb_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev_q <= '0;
            ev_q       <= '0;
        end else begin
            lvl_prev_q <= lvl;
            ev_q       <= lvl & ~lvl_prev_q;
        end
    end

    assign ev_any = |ev_q;

    logic [6:0] a_q, a_d;
    logic [6:0] b_q, b_d;
    logic [3:0] loaded_q, loaded_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (ev_q[0]) a_d[3:0] = y;
        if (ev_q[1]) a_d[6:4] = y[2:0];
        if (ev_q[2]) b_d[3:0] = y;
        if (ev_q[3]) b_d[6:4] = y[2:0];
        loaded_d = loaded_q | ev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            loaded_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            loaded_q <= loaded_d;
        end
    end

    state_e     state_q, state_d;
    logic       pend_q, pend_d;
    logic [2:0] leds_q, leds_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (loaded_d == 4'hF) state_d = COMPARE;
            COMPARE: state_d = LATCH;
            LATCH:   state_d = SHOW;
            SHOW:    if (ev_any || pend_q) state_d = COMPARE;
            default: state_d = IDLE;
        endcase
    end

    // LED registers capture on the COMPARE->LATCH edge so the result is visible during LATCH.
    always_comb begin
        cmp_start = (state_q == COMPARE);
        pend_d    = pend_q;
        leds_d    = leds_q;
        done_d    = done_q;
        case (state_q)
            COMPARE: begin
                leds_d = {cmp_gt, cmp_eq, cmp_lt};
                done_d = 1'b1;
                if (ev_any) pend_d = 1'b1;
            end
            LATCH: begin
                if (ev_any) pend_d = 1'b1;
            end
            SHOW: begin
                if (state_d == COMPARE) begin
                    done_d = 1'b0;
                    pend_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            leds_q <= '0;
            done_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            leds_q <= leds_d;
            done_q <= done_d;
        end
    end

    assign a_out              = a_q;
    assign b_out              = b_q;
    assign {led0, led1, led2} = leds_q;
    assign done               = done_q;

endmodule

// File: tb/tb_seven_bit_cmp_ctrl.sv
// Self-checking bench for seven_bit_cmp_ctrl: directed scenarios plus randomized run against a reference model.
`timescale 1ns/1ps

module tb_seven_bit_cmp_ctrl;

    localparam int unsigned S = 2;
`ifdef SEVEN_BIT_DEBOUNCE_EN
    localparam int unsigned D = 4;
`else
    localparam int unsigned D = 16;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_CMP   = 1;
    localparam int P_LATCH = 2;
    localparam int P_SHOW  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] y = '0;
    logic       pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0, pb4 = 1'b0;
    logic       cmp_gt, cmp_eq, cmp_lt;
    logic [6:0] a_out, b_out;
    logic       cmp_start, led0, led1, led2, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign cmp_gt = (a_out > b_out);
    assign cmp_eq = (a_out == b_out);
    assign cmp_lt = (a_out < b_out);

    seven_bit_cmp_ctrl #(
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .y(y),
        .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4),
        .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .a_out(a_out), .b_out(b_out), .cmp_start(cmp_start),
        .led0(led0), .led1(led1), .led2(led2), .done(done)
    );

    // Reference model: events derived from a raw pin history, operands/LEDs from plain arithmetic.
    logic [6:0] m_a, m_b;
    logic [3:0] m_loaded, m_ev;
    int         m_phase;
    logic       m_pend, m_done;
    logic [2:0] m_leds;
    logic [3:0] m_hist [0:S+1];

    always @(posedge clk or negedge rst_n) begin : ref_model
        logic [3:0] h [0:S+1];
        logic [6:0] na, nb;
        logic [3:0] nl;
        int         nph;
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_loaded <= '0; m_ev <= '0;
            m_phase <= P_IDLE; m_pend <= 1'b0; m_done <= 1'b0; m_leds <= '0;
            for (int i = 0; i < S + 2; i++) m_hist[i] <= '0;
        end else begin
            na = m_a;
            nb = m_b;
            if (m_ev[0]) na[3:0] = y;
            if (m_ev[1]) na[6:4] = y[2:0];
            if (m_ev[2]) nb[3:0] = y;
            if (m_ev[3]) nb[6:4] = y[2:0];
            nl = m_loaded | m_ev;
            case (m_phase)
                P_IDLE:  nph = (nl == 4'hF) ? P_CMP : P_IDLE;
                P_CMP:   nph = P_LATCH;
                P_LATCH: nph = P_SHOW;
                default: nph = ((m_ev != 4'h0) || m_pend) ? P_CMP : P_SHOW;
            endcase
            if (m_phase == P_CMP) begin
                m_leds <= {m_a > m_b, m_a == m_b, m_a < m_b};
                m_done <= 1'b1;
            end else if (nph == P_CMP) begin
                m_done <= 1'b0;
            end
            if ((m_phase == P_CMP || m_phase == P_LATCH) && m_ev != 4'h0) m_pend <= 1'b1;
            else if (nph == P_CMP) m_pend <= 1'b0;
            m_a <= na;
            m_b <= nb;
            m_loaded <= nl;
            m_phase <= nph;
            h[0] = {pb4, pb3, pb2, pb1};
            for (int i = 1; i < S + 2; i++) h[i] = m_hist[i-1];
            for (int i = 0; i < S + 2; i++) m_hist[i] <= h[i];
            m_ev <= h[S] & ~h[S+1];
        end
    end

    task automatic set_pins(input logic [3:0] p);
        {pb4, pb3, pb2, pb1} = p;
    endtask

    task automatic press(input logic [3:0] p, input logic [3:0] yv, input int unsigned hold, input int unsigned gap);
        y = yv;
        set_pins(p);
        repeat (hold) @(negedge clk);
        set_pins('0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        set_pins('0);
        y = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] act;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        act = {a_out, b_out, cmp_start, led0, led1, led2, done};
        n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", act); end
        repeat (3) @(negedge clk);
        act = {a_out, b_out, cmp_start, led0, led1, led2, done};
        n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", act); end
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            act = {a_out, b_out, cmp_start, led0, led1, led2, done};
            n_checks++;
            if (act !== '0) begin n_fail++; $display("FAIL reset_idle[%0d]: got %h expected 0", j, act); end
        end
    endtask

`ifdef SEVEN_BIT_DEBOUNCE_EN
    task automatic test_debounce();
        logic [6:0] exp_b;
        do_reset();
        y = 4'b0111;
        for (int c = 0; c < 20; c++) begin
            set_pins(((c / 2) % 2 == 0) ? 4'b1000 : 4'b0000);
            @(negedge clk);
            n_checks++;
            if (b_out !== 7'h00) begin n_fail++; $display("FAIL debounce_toggle[%0d]: got b=%h expected 00", c, b_out); end
        end
        set_pins(4'b1000);
        for (int j = 1; j <= int'(S + D + 8); j++) begin
            @(negedge clk);
            exp_b = (j >= int'(S + D + 2)) ? 7'h70 : 7'h00;
            n_checks++;
            if (b_out !== exp_b) begin n_fail++; $display("FAIL debounce_hold[%0d]: got b=%h expected %h", j, b_out, exp_b); end
            if (j == int'(S + D + 4)) y = 4'h0;
        end
        set_pins('0);
        repeat (S + D + 4) @(negedge clk);
        n_checks++;
        if (b_out !== 7'h70) begin n_fail++; $display("FAIL debounce_release: got b=%h expected 70", b_out); end
    endtask
`else
    task automatic test_basic();
        press(4'b0001, 4'h1, 2, 6);
        press(4'b0010, 4'h0, 2, 6);
        press(4'b0100, 4'h0, 2, 6);
        y = 4'h0;
        set_pins(4'b1000);
        for (int j = 1; j <= int'(S + 6); j++) begin
            @(negedge clk);
            n_checks++;
            if (cmp_start !== (j == int'(S + 2))) begin
                n_fail++; $display("FAIL basic_cmp_start[%0d]: got %b expected %b", j, cmp_start, (j == int'(S + 2)));
            end
            n_checks++;
            if (j >= int'(S + 3)) begin
                if ({led0, led1, led2, done} !== 4'b1001) begin
                    n_fail++; $display("FAIL basic_leds[%0d]: got %b expected 1001", j, {led0, led1, led2, done});
                end
            end else if (done !== 1'b0) begin
                n_fail++; $display("FAIL basic_done_early[%0d]: got %b expected 0", j, done);
            end
            if (j == 2) set_pins('0);
        end
        n_checks++;
        if ({a_out, b_out} !== {7'h01, 7'h00}) begin
            n_fail++; $display("FAIL basic_operands: got a=%h b=%h expected a=01 b=00", a_out, b_out);
        end
    endtask

    task automatic test_equal_then_lt();
        logic [3:0] exp_ld;
        press(4'b0001, 4'h5, 2, 8);
        press(4'b0010, 4'h3, 2, 8);
        press(4'b0100, 4'h5, 2, 8);
        press(4'b1000, 4'h3, 2, 8);
        n_checks++;
        if ({a_out, b_out, led0, led1, led2, done} !== {7'h35, 7'h35, 4'b0101}) begin
            n_fail++; $display("FAIL equal_result: got a=%h b=%h leds/done=%b expected a=35 b=35 0101",
                               a_out, b_out, {led0, led1, led2, done});
        end
        y = 4'hF;
        set_pins(4'b0100);
        for (int j = 1; j <= int'(S + 6); j++) begin
            @(negedge clk);
            exp_ld[3:1] = (j >= int'(S + 3)) ? 3'b001 : 3'b010;
            exp_ld[0]   = (j != int'(S + 2));
            n_checks++;
            if ({led0, led1, led2, done} !== exp_ld) begin
                n_fail++; $display("FAIL recompare_lt[%0d]: got %b expected %b", j, {led0, led1, led2, done}, exp_ld);
            end
            if (j == 2) set_pins('0);
        end
        n_checks++;
        if (b_out !== 7'h3F) begin n_fail++; $display("FAIL recompare_b: got %h expected 3f", b_out); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(4'b0101, 4'h6, 2, 0);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_checks++;
            if ({cmp_start, done} !== 2'b00) begin
                n_fail++; $display("FAIL simul_no_compare[%0d]: got %b expected 00", j, {cmp_start, done});
            end
        end
        n_checks++;
        if ({a_out, b_out} !== {7'h06, 7'h06}) begin
            n_fail++; $display("FAIL simul_operands: got a=%h b=%h expected 06 06", a_out, b_out);
        end
    endtask

    task automatic test_hold();
        y = 4'b1010;
        set_pins(4'b0010);
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            n_checks++;
            if (cmp_start !== 1'b0) begin n_fail++; $display("FAIL hold_cmp_start[%0d]: got 1 expected 0", j); end
            if (j == int'(S + 1)) begin
                n_checks++;
                if (a_out !== 7'h06) begin n_fail++; $display("FAIL hold_before_load: got %h expected 06", a_out); end
            end
            if (j == int'(S + 2)) begin
                n_checks++;
                if (a_out !== 7'h26) begin n_fail++; $display("FAIL hold_load: got %h expected 26", a_out); end
            end
            if (j == int'(S + 4)) y = 4'hF;
        end
        set_pins('0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (a_out !== 7'h26) begin n_fail++; $display("FAIL hold_single_event: got %h expected 26", a_out); end
    endtask

    task automatic test_reset_mid();
        logic        seen;
        logic [18:0] act;
        seen = 1'b0;
        press(4'b1000, 4'h1, 2, 0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (cmp_start === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid_reach_compare: got no cmp_start expected one within 20 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        act = {a_out, b_out, cmp_start, led0, led1, led2, done};
        n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_mid_async: got %h expected 0", act); end
        @(negedge clk);
        rst_n = 1'b1;
        press(4'b0001, 4'h9, 2, 0);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_checks++;
            if ({cmp_start, done} !== 2'b00) begin
                n_fail++; $display("FAIL reset_mid_no_compare[%0d]: got %b expected 00", j, {cmp_start, done});
            end
        end
        n_checks++;
        if ({a_out, b_out} !== {7'h09, 7'h00}) begin
            n_fail++; $display("FAIL reset_mid_operands: got a=%h b=%h expected 09 00", a_out, b_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sp [$];
        logic [3:0]  sy [$];
        logic [18:0] act, exp;
        do_reset();
        press(4'b0001, 4'($urandom), 2, 6);
        press(4'b0010, 4'($urandom), 2, 6);
        press(4'b0100, 4'($urandom), 2, 6);
        press(4'b1000, 4'($urandom), 2, 8);
        for (int d = 0; d <= 5; d++) begin
            sp.push_back(4'b0001); sy.push_back(4'($urandom));
            for (int k = 0; k < d; k++) begin sp.push_back(4'b0000); sy.push_back(4'($urandom)); end
            sp.push_back((d % 2 == 0) ? 4'b0100 : 4'b1010); sy.push_back(4'($urandom));
            for (int k = 0; k < 12; k++) begin sp.push_back(4'b0000); sy.push_back(4'($urandom)); end
        end
        foreach (sp[i]) begin
            set_pins(sp[i]);
            y = sy[i];
            @(negedge clk);
            act = {a_out, b_out, cmp_start, led0, led1, led2, done};
            exp = {m_a, m_b, (m_phase == P_CMP), m_leds, m_done};
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL back_to_back step %0d: got %h expected %h", i, act, exp); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  held;
        logic [18:0] act, exp;
        held = '0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, 5) == 0) held[n] = ~held[n];
            end
            set_pins(held);
            y = 4'($urandom);
            @(negedge clk);
            act = {a_out, b_out, cmp_start, led0, led1, led2, done};
            exp = {m_a, m_b, (m_phase == P_CMP), m_leds, m_done};
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, act, exp); end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef SEVEN_BIT_DEBOUNCE_EN
        test_debounce();
`else
        test_basic();
        test_equal_then_lt();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
